// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS 8-bit registers behind an auto-incrementing pointer.
// Bus lines are oversampled by clk; SDA is only ever pulled low (open drain).
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NUM_REGS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic [8*NUM_REGS-1:0]       regs_o,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_index,
  output logic                        busy
);

  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } state_t;

  logic          scl_sync1_reg, scl_sync2_reg, scl_prev_reg;
  logic          sda_sync1_reg, sda_sync2_reg, sda_prev_reg;
  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [6:0]    shift_reg, shift_next;
  logic [6:0]    tx_reg, tx_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic          rw_reg, rw_next;
  logic          ack_seen_reg, ack_seen_next;
  logic          sda_oe_reg, sda_oe_next;
  logic          busy_reg, busy_next;
  logic          wr_pulse_reg, wr_pulse_next;
  logic [IW-1:0] wr_index_reg, wr_index_next;
  logic          reg_we;
  logic [7:0]    regs_reg [NUM_REGS];

  logic       scl_rise, scl_fall, start_det, stop_det, byte_done;
  logic [7:0] rx_byte, rd_byte;

  assign scl_rise  = scl_sync2_reg & ~scl_prev_reg;
  assign scl_fall  = ~scl_sync2_reg & scl_prev_reg;
  // SCL must be high on both sides of the SDA edge so a simultaneous SCL fall is not a condition.
  assign start_det = scl_sync2_reg & scl_prev_reg & sda_prev_reg & ~sda_sync2_reg;
  assign stop_det  = scl_sync2_reg & scl_prev_reg & ~sda_prev_reg & sda_sync2_reg;
  assign rx_byte   = {shift_reg, sda_sync2_reg};
  assign byte_done = scl_rise && (bit_cnt_reg == 3'd7);
  assign rd_byte   = regs_reg[ptr_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync1_reg <= 1'b1;
      scl_sync2_reg <= 1'b1;
      scl_prev_reg  <= 1'b1;
      sda_sync1_reg <= 1'b1;
      sda_sync2_reg <= 1'b1;
      sda_prev_reg  <= 1'b1;
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= '0;
      ptr_reg       <= '0;
      rw_reg        <= 1'b0;
      ack_seen_reg  <= 1'b0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      wr_pulse_reg  <= 1'b0;
      wr_index_reg  <= '0;
    end else begin
      scl_sync1_reg <= scl_in;
      scl_sync2_reg <= scl_sync1_reg;
      scl_prev_reg  <= scl_sync2_reg;
      sda_sync1_reg <= sda_in;
      sda_sync2_reg <= sda_sync1_reg;
      sda_prev_reg  <= sda_sync2_reg;
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      ptr_reg       <= ptr_next;
      rw_reg        <= rw_next;
      ack_seen_reg  <= ack_seen_next;
      sda_oe_reg    <= sda_oe_next;
      busy_reg      <= busy_next;
      wr_pulse_reg  <= wr_pulse_next;
      wr_index_reg  <= wr_index_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (reg_we) begin
      regs_reg[ptr_reg] <= rx_byte;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    ptr_next      = ptr_reg;
    rw_next       = rw_reg;
    ack_seen_next = ack_seen_reg;
    sda_oe_next   = sda_oe_reg;
    busy_next     = busy_reg;
    wr_pulse_next = 1'b0;
    wr_index_next = wr_index_reg;
    reg_we        = 1'b0;

    if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else if (start_det) begin
      // Repeated START keeps the pointer so a set-pointer/read sequence works.
      state_next   = ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      // The counter wraps 7 -> 0 at the end of each byte, ready for the next one.
      if (scl_rise && (state_reg inside {ADDR, PTR, WRITE, READ})) begin
        shift_next   = rx_byte[6:0];
        bit_cnt_next = bit_cnt_reg + 3'd1;
      end
      if (byte_done) begin
        ack_seen_next = 1'b0;
      end

      case (state_reg)
        ADDR: begin
          if (byte_done) begin
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_next = ADDR_ACK;
              busy_next  = 1'b1;
              rw_next    = rx_byte[0];
            end else begin
              state_next = IGNORE;
            end
          end
        end
        PTR: begin
          if (byte_done) begin
            ptr_next   = rx_byte[IW-1:0];
            state_next = PTR_ACK;
          end
        end
        WRITE: begin
          if (byte_done) begin
            reg_we        = 1'b1;
            wr_pulse_next = 1'b1;
            wr_index_next = ptr_reg;
            ptr_next      = ptr_reg + IW'(1);
            state_next    = WRITE_ACK;
          end
        end
        ADDR_ACK, PTR_ACK, WRITE_ACK: begin
          // First SCL fall grabs SDA for the ACK; the fall after the 9th rise lets go.
          if (scl_rise) begin
            ack_seen_next = 1'b1;
          end else if (scl_fall) begin
            if (!ack_seen_reg) begin
              sda_oe_next = 1'b1;
            end else if (state_reg == ADDR_ACK && rw_reg) begin
              state_next  = READ;
              tx_next     = rd_byte[6:0];
              sda_oe_next = ~rd_byte[7];
            end else begin
              state_next  = (state_reg == ADDR_ACK) ? PTR : WRITE;
              sda_oe_next = 1'b0;
            end
          end
        end
        READ: begin
          if (byte_done) begin
            ptr_next   = ptr_reg + IW'(1);
            state_next = READ_ACK;
          end else if (scl_fall) begin
            sda_oe_next = ~tx_reg[6];
            tx_next     = {tx_reg[5:0], 1'b0};
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            if (!sda_sync2_reg) begin
              ack_seen_next = 1'b1;
            end else begin
              state_next = IGNORE;
            end
          end else if (scl_fall) begin
            if (ack_seen_reg) begin
              state_next  = READ;
              tx_next     = rd_byte[6:0];
              sda_oe_next = ~rd_byte[7];
            end else begin
              sda_oe_next = 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign regs_o[8*gi +: 8] = regs_reg[gi];
    end
  endgenerate

  assign sda_oe   = sda_oe_reg;
  assign busy     = busy_reg;
  assign wr_pulse = wr_pulse_reg;
  assign wr_index = wr_index_reg;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register-file model, random transactions.
module tb_i2c_target_regs;

  localparam int         NUM_REGS = 4;
  localparam logic [6:0] DEV_ADDR = 7'h50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe, wr_pulse, busy;
  logic [31:0] regs_o;
  logic [1:0]  wr_index;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regs #(.DEV_ADDR(DEV_ADDR), .NUM_REGS(NUM_REGS)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .regs_o   (regs_o),
    .wr_pulse (wr_pulse),
    .wr_index (wr_index),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_regs [NUM_REGS];
  int         m_ptr;
  int         exp_wr_q[$];
  int         act_wr_q[$];
  logic [7:0] wq[$];
  bit         oe_seen, busy_seen;
  int         pulse_viol = 0;
  int         oe_viol = 0;
  logic       oe_prev = 1'b0;
  logic       wrp_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    if (wr_pulse) act_wr_q.push_back(int'(wr_index));
    if (wr_pulse && wrp_prev) pulse_viol++;
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (!reset && (sda_oe !== oe_prev) && scl_m) oe_viol++;
    wrp_prev = wr_pulse;
    oe_prev  = sda_oe;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b;    wait_clks(5);
    scl_m = 1'b1; wait_clks(5);
    s = sda_line; wait_clks(5);
    scl_m = 1'b0; wait_clks(5);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; wait_clks(5);
    scl_m = 1'b1; wait_clks(5);
    sda_m = 1'b0; wait_clks(5);
    scl_m = 1'b0; wait_clks(5);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wait_clks(5);
    scl_m = 1'b1; wait_clks(5);
    sda_m = 1'b1; wait_clks(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      d = {d[6:0], s};
    end
    bus_bit(~m_ack, s);
  endtask

  task automatic model_clear;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    exp_wr_q.delete();
  endtask

  task automatic compare_state(input string name);
    logic [31:0] exp_vec;
    for (int i = 0; i < NUM_REGS; i++) exp_vec[8*i +: 8] = m_regs[i];
    wait_clks(3);
    check_val({name, "_regs"}, regs_o, exp_vec);
    check_val({name, "_busy_idle"}, 32'(busy), 32'd0);
    check_val({name, "_wr_count"}, act_wr_q.size(), exp_wr_q.size());
    for (int i = 0; i < exp_wr_q.size(); i++)
      check_val({name, "_wr_index"}, (i < act_wr_q.size()) ? act_wr_q[i] : 32'hFFFF_FFFF, exp_wr_q[i]);
    act_wr_q.delete();
    exp_wr_q.delete();
  endtask

  // Writes every byte queued in wq starting at pointer p.
  task automatic do_write(input logic [7:0] p);
    logic ack;
    int   n;
    n = wq.size();
    bus_start;
    send_byte({DEV_ADDR, 1'b0}, ack);
    check_val("wr_addr_ack", 32'(ack), 32'd1);
    check_val("wr_busy", 32'(busy), 32'd1);
    send_byte(p, ack);
    check_val("wr_ptr_ack", 32'(ack), 32'd1);
    m_ptr = int'(p) % NUM_REGS;
    while (wq.size() > 0) begin
      logic [7:0] d;
      d = wq.pop_front();
      send_byte(d, ack);
      check_val("wr_data_ack", 32'(ack), 32'd1);
      m_regs[m_ptr] = d;
      exp_wr_q.push_back(m_ptr);
      m_ptr = (m_ptr + 1) % NUM_REGS;
    end
    bus_stop;
    $display("txn write ptr=0x%02h bytes=%0d", p, n);
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] d;
    bus_start;
    if (set_ptr) begin
      send_byte({DEV_ADDR, 1'b0}, ack);
      check_val("rd_waddr_ack", 32'(ack), 32'd1);
      send_byte(p, ack);
      check_val("rd_ptr_ack", 32'(ack), 32'd1);
      m_ptr = int'(p) % NUM_REGS;
      bus_start;
    end
    send_byte({DEV_ADDR, 1'b1}, ack);
    check_val("rd_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, d);
      check_val("rd_data", 32'(d), 32'(m_regs[m_ptr]));
      m_ptr = (m_ptr + 1) % NUM_REGS;
    end
    // After the NACK the target must stay off the bus until STOP.
    oe_seen = 1'b0;
    send_byte(8'($urandom), ack);
    check_val("rd_ignore_oe", 32'(oe_seen), 32'd0);
    check_val("rd_ignore_busy", 32'(busy), 32'd1);
    bus_stop;
    $display("txn read set_ptr=%0d ptr=0x%02h bytes=%0d", set_ptr, p, n);
  endtask

  task automatic do_wrong(input logic [6:0] a);
    logic ack, ack2;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    bus_start;
    send_byte({a, 1'b0}, ack);
    send_byte(8'($urandom), ack2);
    bus_stop;
    check_val("wrong_ack", 32'({ack, ack2}), 32'd0);
    check_val("wrong_oe_seen", 32'(oe_seen), 32'd0);
    check_val("wrong_busy_seen", 32'(busy_seen), 32'd0);
    $display("txn wrong_addr addr=0x%02h", a);
  endtask

  task automatic do_partial(input logic [7:0] p, input int k);
    logic ack, s, b;
    bus_start;
    send_byte({DEV_ADDR, 1'b0}, ack);
    check_val("part_addr_ack", 32'(ack), 32'd1);
    send_byte(p, ack);
    check_val("part_ptr_ack", 32'(ack), 32'd1);
    m_ptr = int'(p) % NUM_REGS;
    for (int i = 0; i < k; i++) begin
      b = 1'($urandom_range(0, 1));
      bus_bit(b, s);
    end
    bus_stop;
    $display("txn partial ptr=0x%02h bits=%0d", p, k);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] p, a8;
    logic [6:0] a;
    int         kind, n;

    model_clear();
    wait_clks(3);
    check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check_val("rst_wr_index", 32'(wr_index), 32'd0);
    check_val("rst_regs", regs_o, 32'd0);
    reset = 1'b0;
    wait_clks(5);

    wq = '{8'h5A};
    do_write(8'h01);
    compare_state("write_basic");

    do_wrong(7'h51);
    compare_state("wrong_addr");

    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(8'h00);
    compare_state("preload");
    do_read(1'b1, 8'h02, 2);
    compare_state("read_rstart");

    wq = '{8'hAA, 8'hBB};
    do_write(8'h03);
    compare_state("ptr_wrap");

    do_partial(8'h00, 5);
    compare_state("partial");

    // Reset pulsed mid data byte while SCL is high.
    bus_start;
    send_byte({DEV_ADDR, 1'b0}, ack);
    send_byte(8'h02, ack);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
    sda_m = 1'b1; wait_clks(5);
    scl_m = 1'b1; wait_clks(2);
    #2;
    reset = 1'b1;
    #1;
    check_val("abort_oe", 32'(sda_oe), 32'd0);
    check_val("abort_regs_async", regs_o, 32'd0);
    wait_clks(2);
    reset = 1'b0;
    wait_clks(3);
    scl_m = 1'b0; wait_clks(5);
    bus_stop;
    model_clear();
    $display("txn abort_reset");
    compare_state("abort");
    wq = '{8'hC3};
    do_write(8'h01);
    compare_state("after_abort");

    // Reset while the target is holding SDA low for the address ACK.
    a8 = {DEV_ADDR, 1'b0};
    bus_start;
    for (int i = 7; i >= 0; i--) bus_bit(a8[i], s);
    sda_m = 1'b1; wait_clks(5);
    check_val("ack_drive", 32'(sda_oe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("reset_release", 32'(sda_oe), 32'd0);
    wait_clks(2);
    reset = 1'b0;
    wait_clks(2);
    scl_m = 1'b1; wait_clks(10);
    scl_m = 1'b0; wait_clks(5);
    bus_stop;
    model_clear();
    $display("txn ack_reset");
    compare_state("ack_reset");

    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 4);
      p = 8'($urandom);
      case (kind)
        0: begin
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
          do_write(p);
        end
        1: do_read(1'b1, p, $urandom_range(1, 3));
        2: do_read(1'b0, p, $urandom_range(1, 2));
        3: begin
          a = 7'($urandom);
          if (a == DEV_ADDR) a = a ^ 7'h01;
          do_wrong(a);
        end
        default: do_partial(p, $urandom_range(1, 7));
      endcase
      compare_state("random");
    end

    check_val("wr_pulse_width", pulse_viol, 0);
    check_val("oe_change_scl_low", oe_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 The module SHALL have parameter DEV_ADDR, default 7'h50, giving the 7-bit bus address this target answers to.
REQ-002 The module SHALL have parameter NUM_REGS, default 4, giving the number of 8-bit registers (power of two, 2..16).
REQ-003 Port clk, input, 1 bit: system clock; SHALL run at least 8x the SCL rate; all logic is rising-edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port scl_in, input, 1 bit: bus SCL level, asynchronous to clk.
REQ-006 Port sda_in, input, 1 bit: bus SDA level, asynchronous to clk.
REQ-007 Port sda_oe, output, 1 bit: 1 = pull SDA low; 0 = release (open-drain, never drives high).
REQ-008 Port regs_o, output, 8*NUM_REGS bits: register contents; reg k occupies bits [8k+7:8k].
REQ-009 Port wr_pulse, output, 1 bit: one-cycle strobe when a data byte is committed to a register.
REQ-010 Port wr_index, output, $clog2(NUM_REGS) bits: register written; valid with wr_pulse.
REQ-011 Port busy, output, 1 bit: 1 from a START that matches DEV_ADDR until the next STOP or START.

Function
REQ-012 scl_in and sda_in SHALL each pass through a 2-flop synchronizer; all detection uses synchronized values plus a third "previous" flop.
REQ-013 START SHALL be detected when synced SDA falls while synced SCL is high; STOP when synced SDA rises while synced SCL is high.
REQ-014 Data bits SHALL be sampled on the synced SCL rising edge, MSB first; the target SHALL change sda_oe only on the cycle after a synced SCL falling edge.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-016 IDLE: START -> ADDR; bit counter cleared; all other bus activity ignored.
REQ-017 ADDR: after the 8th bit, if bits[7:1] == DEV_ADDR -> ADDR_ACK with busy=1; otherwise -> IGNORE with sda_oe held 0.
REQ-018 ADDR_ACK: sda_oe=1 from the SCL fall after bit 8 until the SCL fall after the 9th clock; then R/W=0 -> PTR, R/W=1 -> READ.
REQ-019 PTR: the received byte, taken modulo NUM_REGS, SHALL be loaded into the register pointer; ACK as in REQ-018; then -> WRITE.
REQ-020 WRITE: the received byte SHALL be written to reg[ptr] on the 8th SCL rise; wr_pulse=1 for exactly one clk with wr_index=ptr; ptr increments modulo NUM_REGS (wraps NUM_REGS-1 -> 0); ACK; remain in WRITE for further bytes.
REQ-021 READ: reg[ptr] SHALL be loaded into the shift register on entry; each bit 0 -> sda_oe=1, bit 1 -> sda_oe=0, updated after each SCL fall; ptr increments after the byte.
REQ-022 READ_ACK: sda_oe=0; master ACK (SDA=0 at 9th rise) -> READ with the next byte; NACK -> IGNORE.
REQ-023 IGNORE: sda_oe=0; only START or STOP is acted on.
REQ-024 STOP in any state SHALL go to IDLE with sda_oe=0 and busy=0 on the next clk; a partial byte is discarded.
REQ-025 START in any non-IDLE state (repeated START) SHALL go to ADDR and preserve the pointer, so a write-pointer/repeated-start/read sequence reads from the set pointer.
REQ-026 START/STOP detection SHALL take priority over a simultaneous bit-sample event.
REQ-027 A write of a partial byte (fewer than 8 bits before STOP/START) SHALL NOT modify any register or pulse wr_pulse.

Reset
REQ-028 While reset=1: state=IDLE, sda_oe=0, busy=0, wr_pulse=0, wr_index=0, pointer=0, bit counter=0, all registers 0, synchronizer flops=1.
REQ-029 Reset asserted mid-transfer SHALL release SDA within the same clk (asynchronous); after release the block stays in IDLE until a fresh START.

Verification
REQ-030 Write: START, 0xA0, ptr 0x01, data 0x5A, STOP -> three ACKs, reg1=0x5A, one wr_pulse with wr_index=1, busy low after STOP.
REQ-031 Wrong address: START, 0xA2 (addr 0x51), STOP -> sda_oe never asserted, busy never 1, registers unchanged.
REQ-032 Read with repeated START: regs=0x11,0x22,0x33,0x44; START 0xA0, ptr 0x02, rSTART 0xA1, master ACK, then NACK -> bytes 0x33 then 0x44 on SDA, FSM enters IGNORE, then IDLE on STOP.
REQ-033 Pointer wrap: START 0xA0, ptr 0x03, data 0xAA, 0xBB, STOP -> reg3=0xAA, reg0=0xBB, wr_index sequence 3,0.
REQ-034 Abort: reset pulsed during bit 4 of a data byte, then STOP -> sda_oe=0 at once, all registers 0, no wr_pulse; a following full write succeeds normally.
REQ-035 Partial byte: START 0xA0, ptr 0x00, 5 data bits, STOP -> reg0 unchanged, no wr_pulse.
